spi_flash_rd: RTL and testbench
===============================

# spi_flash_rd

Single-IO SPI flash read controller that turns 32-bit word reads on the native memory bus into JEDEC READ (0x03) transactions. It drives the flash_io*_oe / flash_io*_do lines that the tri-state pad buffers consume and samples flash_io1_di coming back from them. A one-shot wake-up command (0xAB, release from deep power-down) is sent after reset, before any bus read is served.

## Interface
- CMD_READ, 8'h03, opcode sent for every bus read
- CMD_WAKE, 8'hAB, opcode sent once after reset
- clk  in  1  system clock; all logic on rising edge
- resetn  in  1  asynchronous, active-low reset
- mem_valid  in  1  read request; held until mem_ready
- mem_ready  out  1  one-cycle completion pulse
- mem_addr  in  24  byte address; bits [1:0] ignored
- mem_rdata  out  32  read data, valid while mem_ready=1
- flash_csb  out  1  chip select, active low
- flash_clk  out  1  SPI clock, mode 0
- flash_io0_oe  out  1  MOSI output enable
- flash_io0_do  out  1  MOSI data
- flash_io1_oe  out  1  constant 0 (MISO is input)
- flash_io1_do  out  1  constant 0
- flash_io1_di  in  1  MISO data from pad buffer
- flash_io2_oe, flash_io3_oe  out  1 each  constant 1 (drive WP#/HOLD#)
- flash_io2_do, flash_io3_do  out  1 each  constant 1

## Operation
- All outputs are registered. Reset values: flash_csb=1, flash_clk=0, flash_io0_oe=0, flash_io0_do=0, mem_ready=0, mem_rdata=0. The io1/io2/io3 constants hold during reset.
- States: WAKE → WAKE_GAP → IDLE → XFER → DONE → IDLE.
- WAKE: entered on the first edge after resetn deasserts. Shifts CMD_WAKE MSB-first, 8 bits, csb low, io0_oe=1.
- WAKE_GAP: csb high, io0_oe=0 for 2 cycles, then IDLE. Requests arriving earlier wait and are not lost (mem_valid stays high).
- IDLE: csb high, clk low. Accepts when mem_valid=1 and mem_ready=0.
- XFER: 64 SPI bits, MSB-first per field:
  - opcode (8)
  - address {mem_addr[23:2],2'b00} (24), io0_oe=1 during these 32 bits
  - data (32), io0_oe=0 and io0_do=0 during these bits
- Byte assembly: the first received byte goes to rdata[7:0], the second to [15:8], and so on (little-endian word). Within each byte, the first bit received is bit 7.
- DONE: mem_ready=1 and csb=1 for exactly one cycle, then IDLE. Any mem_valid seen in the DONE cycle is ignored, so the minimum csb-high time between transfers is 2 cycles.
- mem_rdata holds its value until the next completion.
- If mem_valid drops during XFER (protocol violation), the transfer still completes and mem_ready still pulses.
- A 6-bit bit counter plus a 1-bit phase counter drive the shifter; the counter wraps only through state exit.

## Timing
- Each SPI bit lasts 2 clk cycles:
  - phase 0: flash_clk=0, io0_do presents the new bit
  - phase 1: flash_clk=1
- flash_io1_di is sampled on the rising clk edge that ends phase 1. flash_clk is clk/2.
- Let edge A be the edge that accepts a request. Then:
  - csb falls and phase 0 of opcode bit 7 begins in the cycle after A.
  - The last data bit is captured at edge A+128.
  - mem_ready is high in the cycle after edge A+128, giving 129-cycle latency.
- Wake-up takes 16 cycles of clocking plus 1 csb-setup cycle and 2 gap cycles. The first request can be accepted no earlier than edge 20 after reset release.
- resetn asserted mid-transfer: all outputs go to reset values immediately and asynchronously, csb rises without completing the transfer, and no mem_ready is issued. The wake-up sequence reruns after release.

## Test plan
- Reset release, no requests: csb low for 17 cycles, io0_do serial pattern 1,0,1,0,1,0,1,1 on 8 flash_clk rising edges, then csb high and io0_oe=0.
- Single read, mem_addr=24'h10_0007, flash model returns bytes 0x11,0x22,0x33,0x44: MOSI carries 0x03 then 0x100004, mem_rdata=32'h4433_2211, and mem_ready pulses exactly once, 129 cycles after acceptance.
- Back-to-back reads with mem_valid held through the DONE cycle, then re-asserted: no double acceptance, csb high for exactly 2 cycles between frames, two ready pulses.
- Request asserted at edge 3 after reset: waits for wake-up to finish, is accepted at edge 20, and returns correct data.
- resetn pulsed low at bit 40 of XFER: csb=1, flash_clk=0, and mem_ready=0 immediately; after release the wake frame repeats and a new read returns correct data.
- Throughout all of the above: io1_oe=0, io2/io3 oe=1 and do=1 constantly; io0_oe=0 whenever csb=1 or during data bits.

Source files
------------

// File: rtl/spi_flash_rd.sv
// spi_flash_rd: single-IO SPI flash read controller.
// Sends a one-shot 0xAB wake-up frame after reset. It then serves each 32-bit
// bus read with a JEDEC READ (0x03) frame: 8 opcode bits, 24 address bits,
// then 32 data bits returned as a little-endian word.
module spi_flash_rd (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [23:0] mem_addr,
  output logic [31:0] mem_rdata,
  output logic        flash_csb,
  output logic        flash_clk,
  output logic        flash_io0_oe,
  output logic        flash_io0_do,
  output logic        flash_io1_oe,
  output logic        flash_io1_do,
  input  logic        flash_io1_di,
  output logic        flash_io2_oe,
  output logic        flash_io2_do,
  output logic        flash_io3_oe,
  output logic        flash_io3_do
);

  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] CMD_WAKE = 8'hAB;

  typedef enum logic [2:0] {
    S_WAKE,
    S_WAKE_GAP,
    S_IDLE,
    S_XFER,
    S_DONE
  } state_t;

  state_t      state;
  logic [5:0]  bit_cnt;  // SPI bit index in XFER; step counter in WAKE/WAKE_GAP
  logic        phase;    // 0: flash_clk low, new bit on io0; 1: flash_clk high
  logic [31:0] tx_sr;    // opcode + address, bit 31 is the bit currently on io0
  logic [31:0] rx_sr;    // received data bits, first received bit ends up in bit 31
  logic [31:0] rx_next;
  logic [3:0]  wake_idx;

  // io1 is MISO (input only); WP#/HOLD# are held inactive (high) at all times.
  assign flash_io1_oe = 1'b0;
  assign flash_io1_do = 1'b0;
  assign flash_io2_oe = 1'b1;
  assign flash_io2_do = 1'b1;
  assign flash_io3_oe = 1'b1;
  assign flash_io3_do = 1'b1;

  // Receive shift including the bit being sampled on this edge, so the final
  // data bit can go straight into mem_rdata on the same edge.
  assign rx_next  = {rx_sr[30:0], flash_io1_di};
  // In WAKE, step 0 is the csb-setup cycle; steps 1..16 are the 8 bit pairs.
  assign wake_idx = 4'(bit_cnt - 6'd1);

  // Main controller FSM; all flash and bus outputs are registered here.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= S_WAKE;
      bit_cnt      <= 6'd0;
      phase        <= 1'b0;
      tx_sr        <= 32'd0;
      rx_sr        <= 32'd0;
      flash_csb    <= 1'b1;
      flash_clk    <= 1'b0;
      flash_io0_oe <= 1'b0;
      flash_io0_do <= 1'b0;
      mem_ready    <= 1'b0;
      mem_rdata    <= 32'd0;
    end else begin
      case (state)
        S_WAKE: begin
          if (bit_cnt == 6'd17) begin
            state        <= S_WAKE_GAP;
            bit_cnt      <= 6'd0;
            flash_csb    <= 1'b1;
            flash_clk    <= 1'b0;
            flash_io0_oe <= 1'b0;
            flash_io0_do <= 1'b0;
          end else begin
            bit_cnt      <= bit_cnt + 6'd1;
            flash_csb    <= 1'b0;
            flash_io0_oe <= 1'b1;
            if (bit_cnt == 6'd0) begin
              // csb-setup cycle: MSB already on io0 before the first clock rise
              flash_clk    <= 1'b0;
              flash_io0_do <= CMD_WAKE[7];
            end else begin
              flash_clk    <= wake_idx[0];
              flash_io0_do <= CMD_WAKE[~wake_idx[3:1]];
            end
          end
        end

        S_WAKE_GAP: begin
          // Two cycles of csb high before the first read may start
          if (bit_cnt[0]) begin
            state   <= S_IDLE;
            bit_cnt <= 6'd0;
          end else begin
            bit_cnt <= 6'd1;
          end
        end

        S_IDLE: begin
          if (mem_valid && !mem_ready) begin
            state        <= S_XFER;
            bit_cnt      <= 6'd0;
            phase        <= 1'b0;
            tx_sr        <= {CMD_READ, mem_addr & 24'hFF_FFFC};
            flash_csb    <= 1'b0;
            flash_clk    <= 1'b0;
            flash_io0_oe <= 1'b1;
            flash_io0_do <= CMD_READ[7];
          end
        end

        S_XFER: begin
          if (!phase) begin
            phase     <= 1'b1;
            flash_clk <= 1'b1;
          end else begin
            phase     <= 1'b0;
            flash_clk <= 1'b0;
            if (bit_cnt[5]) begin
              rx_sr <= rx_next;
            end
            if (bit_cnt == 6'd63) begin
              state        <= S_DONE;
              flash_csb    <= 1'b1;
              flash_io0_oe <= 1'b0;
              flash_io0_do <= 1'b0;
              mem_ready    <= 1'b1;
              // First received byte lands in the low byte of the word
              mem_rdata    <= {rx_next[7:0], rx_next[15:8],
                               rx_next[23:16], rx_next[31:24]};
            end else begin
              bit_cnt <= bit_cnt + 6'd1;
              tx_sr   <= {tx_sr[30:0], 1'b0};
              if (bit_cnt < 6'd31) begin
                flash_io0_oe <= 1'b1;
                flash_io0_do <= tx_sr[30];
              end else begin
                // Data phase: release MOSI and keep it low
                flash_io0_oe <= 1'b0;
                flash_io0_do <= 1'b0;
              end
            end
          end
        end

        S_DONE: begin
          // Requests seen here are ignored; this keeps csb high for 2 cycles
          mem_ready <= 1'b0;
          state     <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_rd.sv
// tb_spi_flash_rd: directed bench for spi_flash_rd with a behavioural SPI flash.
module tb_spi_flash_rd;

  logic        clk;
  logic        resetn;
  logic        mem_valid;
  logic        mem_ready;
  logic [23:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        flash_csb, flash_clk;
  logic        flash_io0_oe, flash_io0_do;
  logic        flash_io1_oe, flash_io1_do, flash_io1_di;
  logic        flash_io2_oe, flash_io2_do, flash_io3_oe, flash_io3_do;

  int n_checks = 0;
  int n_err    = 0;

  spi_flash_rd dut (
    .clk          (clk),
    .resetn       (resetn),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .flash_csb    (flash_csb),
    .flash_clk    (flash_clk),
    .flash_io0_oe (flash_io0_oe),
    .flash_io0_do (flash_io0_do),
    .flash_io1_oe (flash_io1_oe),
    .flash_io1_do (flash_io1_do),
    .flash_io1_di (flash_io1_di),
    .flash_io2_oe (flash_io2_oe),
    .flash_io2_do (flash_io2_do),
    .flash_io3_oe (flash_io3_oe),
    .flash_io3_do (flash_io3_do)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge index since reset release: the first rising edge after release is edge 0.
  int edge_no;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) edge_no <= -1;
    else         edge_no <= edge_no + 1;
  end

  // Behavioural flash: records MOSI per frame and returns flash_stream MSB-first
  // during bits 32..63 (byte sent first sits in flash_stream[31:24]).
  logic [31:0] flash_stream;
  logic [63:0] mosi_sr, last_mosi;
  int          nbits, last_nbits;
  int          viol_model = 0;
  logic        csb_q = 1'b1;
  logic        fclk_q = 1'b0;
  initial flash_io1_di = 1'b0;

  always @(flash_csb, flash_clk) begin
    if (flash_csb !== csb_q) begin
      if (flash_csb === 1'b0) begin
        nbits   = 0;
        mosi_sr = 64'd0;
      end else begin
        last_nbits   = nbits;
        last_mosi    = mosi_sr;
        flash_io1_di = 1'b0;
      end
    end else if (flash_clk === 1'b1 && fclk_q === 1'b0 && flash_csb === 1'b0) begin
      mosi_sr = {mosi_sr[62:0], flash_io0_do};
      if (nbits >= 32 && nbits < 64) begin
        if (flash_io0_oe !== 1'b0) viol_model++;
        flash_io1_di = flash_stream[31 - (nbits - 32)];
      end else begin
        if (flash_io0_oe !== 1'b1) viol_model++;
        flash_io1_di = 1'b0;
      end
      nbits++;
    end
    csb_q  = flash_csb;
    fclk_q = flash_clk;
  end

  // Continuous monitor of constant pads, io0_oe vs csb, and ready pulse width.
  int   viol_mon  = 0;
  int   ready_cnt = 0;
  logic ready_prev = 1'b0;
  always @(negedge clk) begin
    if (flash_io1_oe !== 1'b0 || flash_io1_do !== 1'b0 ||
        flash_io2_oe !== 1'b1 || flash_io2_do !== 1'b1 ||
        flash_io3_oe !== 1'b1 || flash_io3_do !== 1'b1) viol_mon++;
    if (flash_csb === 1'b1 && flash_io0_oe !== 1'b0) viol_mon++;
    if (mem_ready === 1'b1) begin
      ready_cnt++;
      if (ready_prev === 1'b1) viol_mon++;
    end
    ready_prev = mem_ready;
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Issue one read (caller is at a falling clk edge). Records the edge that
  // began the read frame (csb low) and the edge whose cycle carries mem_ready.
  task automatic do_read(input logic [23:0] addr, input logic [31:0] strm, input bit keep,
                         output logic [31:0] rd, output int a_e, output int r_e);
    logic prev;
    bit   ok;
    mem_addr     = addr;
    flash_stream = strm;
    mem_valid    = 1'b1;
    a_e  = -1;
    r_e  = -1;
    ok   = 1'b0;
    rd   = 32'd0;
    prev = flash_csb;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (flash_csb === 1'b0 && prev === 1'b1) a_e = edge_no;
      prev = flash_csb;
      if (mem_ready === 1'b1) begin
        ok  = 1'b1;
        rd  = mem_rdata;
        r_e = edge_no;
      end
    end
    if (!keep) mem_valid = 1'b0;
    chk("read_completes", 64'(ok), 64'd1);
    $display("read addr=%06h rdata=%08h accept_edge=%0d ready_edge=%0d", addr, rd, a_e, r_e);
  endtask

  // Watch the wake frame right after reset release (caller is at a falling edge).
  task automatic check_wake(input string tag);
    int lowc, first;
    lowc  = 0;
    first = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (flash_csb === 1'b0) begin
        lowc++;
        if (first < 0) first = edge_no;
      end
    end
    chk({tag, "_csb_low_cycles"}, 64'(lowc), 64'd17);
    chk({tag, "_csb_fall_edge"}, 64'(first), 64'd0);
    chk({tag, "_clk_rises"}, 64'(last_nbits), 64'd8);
    chk({tag, "_opcode"}, {56'd0, last_mosi[7:0]}, 64'hAB);
    $display("wake %s: csb_low=%0d bits=%0d opcode=%02h", tag, lowc, last_nbits, last_mosi[7:0]);
  endtask

  typedef struct {
    logic [23:0] addr;
    logic [31:0] strm;       // bytes in send order, first byte in [31:24]
    logic [31:0] exp_rdata;
    logic [31:0] exp_mosi;   // opcode + aligned address
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [31:0] rd, rd2;
    int a_e, r_e, a2, r2, rc0;

    vecs[0] = '{24'h10_0007, 32'h1122_3344, 32'h4433_2211, 32'h0310_0004};
    vecs[1] = '{24'h00_0000, 32'hDEAD_BEEF, 32'hEFBE_ADDE, 32'h0300_0000};
    vecs[2] = '{24'hFF_FFFF, 32'h8000_0001, 32'h0100_0080, 32'h03FF_FFFC};
    vecs[3] = '{24'h12_3456, 32'hA5C3_F00F, 32'h0FF0_C3A5, 32'h0312_3454};

    mem_valid    = 1'b0;
    mem_addr     = 24'd0;
    flash_stream = 32'd0;
    resetn       = 1'b1;
    #2 resetn    = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_csb",   64'(flash_csb), 64'd1);
    chk("rst_fclk",  64'(flash_clk), 64'd0);
    chk("rst_io0oe", 64'(flash_io0_oe), 64'd0);
    chk("rst_io0do", 64'(flash_io0_do), 64'd0);
    chk("rst_ready", 64'(mem_ready), 64'd0);
    chk("rst_rdata", 64'(mem_rdata), 64'd0);
    chk("rst_io2oe", 64'(flash_io2_oe), 64'd1);

    resetn = 1'b1;
    check_wake("wake1");

    // Table-driven single reads
    for (int v = 0; v < 4; v++) begin
      do_read(vecs[v].addr, vecs[v].strm, 1'b0, rd, a_e, r_e);
      chk($sformatf("v%0d_rdata", v), 64'(rd), 64'(vecs[v].exp_rdata));
      chk($sformatf("v%0d_mosi_cmd", v), {32'd0, last_mosi[63:32]}, 64'(vecs[v].exp_mosi));
      chk($sformatf("v%0d_mosi_data_low", v), {32'd0, last_mosi[31:0]}, 64'd0);
      chk($sformatf("v%0d_nbits", v), 64'(last_nbits), 64'd64);
      chk($sformatf("v%0d_latency", v), 64'(r_e - a_e), 64'd128);
      repeat (2) @(negedge clk);
    end

    // mem_rdata holds until the next completion
    repeat (5) @(negedge clk);
    chk("rdata_hold", 64'(mem_rdata), 64'(vecs[3].exp_rdata));

    // Back-to-back with mem_valid held through DONE
    rc0 = ready_cnt;
    do_read(vecs[1].addr, vecs[1].strm, 1'b1, rd, a_e, r_e);
    do_read(vecs[2].addr, vecs[2].strm, 1'b0, rd2, a2, r2);
    repeat (4) @(negedge clk);
    chk("b2b_rdata0", 64'(rd), 64'(vecs[1].exp_rdata));
    chk("b2b_rdata1", 64'(rd2), 64'(vecs[2].exp_rdata));
    chk("b2b_csb_gap", 64'(a2 - r_e), 64'd2);
    chk("b2b_accept_spacing", 64'(a2 - a_e), 64'd130);
    chk("b2b_ready_pulses", 64'(ready_cnt - rc0), 64'd2);

    // Request at edge 3 waits for wake-up, accepted at edge 20
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 10 && edge_no != 2; i++) @(negedge clk);
    chk("early_req_at_edge2", 64'(edge_no), 64'd2);
    do_read(vecs[3].addr, vecs[3].strm, 1'b0, rd, a_e, r_e);
    chk("early_accept_edge", 64'(a_e), 64'd20);
    chk("early_rdata", 64'(rd), 64'(vecs[3].exp_rdata));
    chk("early_latency", 64'(r_e - a_e), 64'd128);
    repeat (2) @(negedge clk);

    // Reset pulse in the middle of a transfer
    rc0          = ready_cnt;
    mem_addr     = vecs[0].addr;
    flash_stream = vecs[0].strm;
    mem_valid    = 1'b1;
    for (int i = 0; i < 300 && !(flash_csb === 1'b0 && nbits >= 40); i++) @(negedge clk);
    chk("midrst_reached_bit40", 64'(nbits), 64'd40);
    resetn = 1'b0;
    #1;
    chk("midrst_csb", 64'(flash_csb), 64'd1);
    chk("midrst_fclk", 64'(flash_clk), 64'd0);
    chk("midrst_ready", 64'(mem_ready), 64'd0);
    chk("midrst_io0oe", 64'(flash_io0_oe), 64'd0);
    mem_valid = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    check_wake("wake2");
    chk("midrst_no_ready", 64'(ready_cnt - rc0), 64'd0);
    do_read(vecs[0].addr, vecs[0].strm, 1'b0, rd, a_e, r_e);
    chk("post_rst_rdata", 64'(rd), 64'(vecs[0].exp_rdata));
    repeat (3) @(negedge clk);

    chk("pad_monitor_violations", 64'(viol_mon), 64'd0);
    chk("io0_oe_phase_violations", 64'(viol_model), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
